// File: rtl/spi_sensor_responder.sv
// Mode-3 SPI target modelling a 3-axis accelerometer: 64x8 register file, single and
// burst access, oversampled in the clk domain, with host-side axis sample injection.
module spi_sensor_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        miso_oe,
  output logic        busy,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_WAIT_CS = 3'd0,
    S_IDLE    = 3'd1,
    S_CMD     = 3'd2,
    S_RD      = 3'd3,
    S_WR      = 3'd4
  } state_t;

  // Handshake: a byte is complete on the 8th synchronized rising spi_clk edge;
  // wr_strobe is a single-cycle valid with no ready (the host must take it).

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic        r_cs_meta, r_cs_sync;
  logic        r_mosi_meta, r_mosi_sync;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_shift;
  logic        r_mb;
  logic [5:0]  r_addr;
  logic [7:0]  r_tx;
  logic        r_miso, r_oe, r_busy;
  logic        r_wr_strobe;
  logic [5:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic [7:0]  r_regs [64];
  logic        r_pend_valid;
  logic [15:0] r_pend_x, r_pend_y, r_pend_z;

  logic        w_rise, w_fall, w_byte_done, w_ro, w_wr_en;
  logic        w_smp_now, w_smp_pend;
  logic [7:0]  w_in_byte;
  logic [5:0]  w_next_addr;
  logic [15:0] w_smp_x, w_smp_y, w_smp_z;

  assign w_rise      = r_sclk_sync & ~r_sclk_prev;
  assign w_fall      = ~r_sclk_sync & r_sclk_prev;
  assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);
  assign w_in_byte   = {r_shift, r_mosi_sync};
  assign w_next_addr = r_mb ? r_addr + 6'd1 : r_addr;
  assign w_ro        = (r_addr == 6'h00) || (r_addr >= 6'h32 && r_addr <= 6'h37);
  assign w_wr_en     = (r_state == S_WR) && w_byte_done && !w_ro;
  assign w_smp_now   = sample_valid & ~r_busy;
  assign w_smp_pend  = r_pend_valid & ~r_busy;
  assign w_smp_x     = w_smp_now ? sample_x : r_pend_x;
  assign w_smp_y     = w_smp_now ? sample_y : r_pend_y;
  assign w_smp_z     = w_smp_now ? sample_z : r_pend_z;

  // CS sync resets low so a frame already in flight at reset is never mistaken for idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_meta <= 1'b1;
      r_sclk_sync <= 1'b1;
      r_sclk_prev <= 1'b1;
      r_cs_meta   <= 1'b0;
      r_cs_sync   <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_sclk_meta <= spi_clk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_cs_meta   <= spi_cs;
      r_cs_sync   <= r_cs_meta;
      r_mosi_meta <= spi_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_WAIT_CS;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_CS: if (r_cs_sync) w_state_nxt = S_IDLE;
      S_IDLE:    if (!r_cs_sync) w_state_nxt = S_CMD;
      S_CMD: begin
        if (r_cs_sync)        w_state_nxt = S_IDLE;
        else if (w_byte_done) w_state_nxt = w_in_byte[7] ? S_RD : S_WR;
      end
      S_RD, S_WR: if (r_cs_sync) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_WAIT_CS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      r_mb        <= 1'b0;
      r_addr      <= 6'd0;
      r_tx        <= 8'd0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 6'd0;
      r_wr_data   <= 8'd0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_busy      <= ~r_cs_sync & (r_state != S_WAIT_CS);
      case (r_state)
        S_CMD: begin
          if (w_rise) begin
            r_shift   <= w_in_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
              r_mb   <= w_in_byte[6];
              r_addr <= w_in_byte[5:0];
              r_tx   <= r_regs[w_in_byte[5:0]];
            end
          end
        end
        S_RD: begin
          if (w_fall) begin
            r_miso <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b0};
            r_oe   <= 1'b1;
          end else if (w_rise) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
              r_addr <= w_next_addr;
              r_tx   <= r_regs[w_next_addr];
            end
          end
        end
        S_WR: begin
          if (w_rise) begin
            r_shift   <= w_in_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
              r_addr <= w_next_addr;
              if (!w_ro) begin
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_addr;
                r_wr_data   <= w_in_byte;
              end
            end
          end
        end
        default: begin
          r_bit_cnt <= 3'd0;
          r_miso    <= 1'b0;
          r_oe      <= 1'b0;
        end
      endcase
    end
  end

  // A sample arriving mid-frame waits here so a burst never mixes old and new axes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_x     <= 16'd0;
      r_pend_y     <= 16'd0;
      r_pend_z     <= 16'd0;
    end else if (sample_valid && r_busy) begin
      r_pend_valid <= 1'b1;
      r_pend_x     <= sample_x;
      r_pend_y     <= sample_y;
      r_pend_z     <= sample_z;
    end else if (!r_busy) begin
      r_pend_valid <= 1'b0;
    end
  end

  // Bus write is assigned last so it wins over a sample update in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) r_regs[i] <= 8'h00;
      r_regs[6'h00] <= DEVID;
      r_regs[6'h2C] <= BW_RATE_RST;
    end else begin
      if (w_smp_now || w_smp_pend) begin
        r_regs[6'h32] <= w_smp_x[7:0];
        r_regs[6'h33] <= w_smp_x[15:8];
        r_regs[6'h34] <= w_smp_y[7:0];
        r_regs[6'h35] <= w_smp_y[15:8];
        r_regs[6'h36] <= w_smp_z[7:0];
        r_regs[6'h37] <= w_smp_z[15:8];
      end
      if (w_wr_en) r_regs[r_addr] <= w_in_byte;
    end
  end

  assign spi_miso    = r_miso;
  assign miso_oe     = r_oe;
  assign busy        = r_busy;
  assign wr_strobe   = r_wr_strobe;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Bench for spi_sensor_responder: SPI master driver, register-file reference model,
// and a monitor that pops expected MISO bytes and write strobes from queues.
module tb_spi_sensor_responder;
  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_clk = 1'b1;
  logic        spi_cs = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_x = 16'd0;
  logic [15:0] sample_y = 16'd0;
  logic [15:0] sample_z = 16'd0;
  logic        spi_miso, miso_oe, busy, wr_strobe;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [2:0]  dbg_state;

  spi_sensor_responder dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .miso_oe(miso_oe), .busy(busy),
    .sample_valid(sample_valid), .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  logic [13:0] exp_wr_q[$];

  // reference model: plain register array plus one pending sample
  logic [7:0]  m_regs [64];
  logic        m_pend;
  logic [15:0] m_px, m_py, m_pz;
  logic [5:0]  m_last_addr;
  logic [7:0]  m_last_data;

  int   spot_kind = 0;
  logic spot_busy = 1'b0;
  logic spot_oe = 1'b0;
  logic done = 1'b0;

  function automatic logic model_ro(input logic [5:0] a);
    return (a == 6'h00) || (a >= 6'h32 && a <= 6'h37);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_regs[0]  = 8'hE5;
    m_regs[44] = 8'h0A;
    m_pend = 1'b0;
    m_last_addr = 6'd0;
    m_last_data = 8'd0;
  endtask

  task automatic model_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    m_regs[50] = x[7:0];  m_regs[51] = x[15:8];
    m_regs[52] = y[7:0];  m_regs[53] = y[15:8];
    m_regs[54] = z[7:0];  m_regs[55] = z[15:8];
  endtask

  // driver tasks
  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spot(input int k);
    @(posedge clk); #1 spot_kind = k;
    @(posedge clk); #1 spot_kind = 0;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_clk = 1'b0;
      spi_mosi = b[7-i];
      clk_wait(HALF);
      spi_clk = 1'b1;
      clk_wait(HALF);
    end
  endtask

  task automatic send_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sample_x = x; sample_y = y; sample_z = z; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    model_sample(x, y, z);
    clk_wait(2);
  endtask

  task automatic frame(input logic [7:0] cmd, input int nbytes, input int wdata,
                       input logic mid, input logic [15:0] mx, input logic [15:0] my,
                       input logic [15:0] mz, input int abort_bits);
    logic [5:0] a;
    logic [7:0] d;
    a = cmd[5:0];
    @(negedge clk);
    spi_cs = 1'b0;
    clk_wait(6);
    spi_bits(cmd, 8);
    if (mid) begin
      @(negedge clk);
      sample_x = mx; sample_y = my; sample_z = mz; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      m_pend = 1'b1; m_px = mx; m_py = my; m_pz = mz;
    end
    for (int k = 0; k < nbytes; k++) begin
      d = (wdata < 0) ? 8'($urandom_range(0, 255)) : 8'(wdata);
      if (cmd[7]) exp_q.push_back(m_regs[a]);
      else if (!model_ro(a)) begin
        m_regs[a] = d;
        exp_wr_q.push_back({a, d});
        m_last_addr = a;
        m_last_data = d;
      end
      spi_bits(d, 8);
      if (k == 0) begin
        spot_busy = 1'b1;
        spot_oe = cmd[7];
        spot(2);
        @(negedge clk);
      end
      if (cmd[6]) a = a + 6'd1;
    end
    if (abort_bits > 0) spi_bits(8'($urandom_range(0, 255)), abort_bits);
    clk_wait(HALF);
    spi_cs = 1'b1;
    clk_wait(10);
    if (m_pend) begin
      model_sample(m_px, m_py, m_pz);
      m_pend = 1'b0;
    end
    spot_busy = 1'b0;
    spot_oe = 1'b0;
    spot(2);
  endtask

  // monitor / scoreboard
  logic       mon_prev_sclk = 1'b1;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'd0;
  logic [7:0] mon_exp;
  logic [13:0] mon_wexp;

  always @(negedge clk) begin
    if (spi_cs) mon_cnt = 0;
    else if (spi_clk && !mon_prev_sclk && miso_oe) begin
      mon_byte = {mon_byte[6:0], spi_miso};
      mon_cnt++;
      if (mon_cnt == 8) begin
        mon_cnt = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL miso_byte: got %02h, expected no byte", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_byte !== mon_exp) begin
            errors++;
            $display("FAIL miso_byte: got %02h, expected %02h", mon_byte, mon_exp);
          end
        end
      end
    end
    mon_prev_sclk = spi_clk;

    if (!rst && wr_strobe) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_strobe: unexpected strobe addr=%02h data=%02h", wr_addr, wr_data);
      end else begin
        mon_wexp = exp_wr_q.pop_front();
        if ({wr_addr, wr_data} !== mon_wexp) begin
          errors++;
          $display("FAIL wr_strobe: got addr=%02h data=%02h, expected addr=%02h data=%02h",
                   wr_addr, wr_data, mon_wexp[13:8], mon_wexp[7:0]);
        end
      end
    end

    case (spot_kind)
      1: begin
        checks++;
        if ({spi_miso, miso_oe, busy, wr_strobe, wr_addr, wr_data, dbg_state} !== 20'd0) begin
          errors++;
          $display("FAIL reset_state: miso=%b oe=%b busy=%b strobe=%b addr=%02h data=%02h state=%0d, expected all 0",
                   spi_miso, miso_oe, busy, wr_strobe, wr_addr, wr_data, dbg_state);
        end
      end
      2: begin
        checks++;
        if (busy !== spot_busy || miso_oe !== spot_oe) begin
          errors++;
          $display("FAIL busy_oe: got busy=%b oe=%b, expected busy=%b oe=%b",
                   busy, miso_oe, spot_busy, spot_oe);
        end
      end
      3: begin
        checks++;
        if ({wr_addr, wr_data} !== {m_last_addr, m_last_data}) begin
          errors++;
          $display("FAIL wr_hold: got addr=%02h data=%02h, expected addr=%02h data=%02h",
                   wr_addr, wr_data, m_last_addr, m_last_data);
        end
      end
      default: ;
    endcase

    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL miso_drain: %0d bytes never seen, expected 0", exp_q.size());
      end
      checks++;
      if (exp_wr_q.size() != 0) begin
        errors++;
        $display("FAIL strobe_drain: %0d strobes never seen, expected 0", exp_wr_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // stimulus
  initial begin
    logic [7:0] rcmd;
    model_reset();
    clk_wait(4);
    spot(1);
    @(negedge clk);
    rst = 1'b0;
    clk_wait(6);

    frame(8'h80, 1, -1, 1'b0, 16'd0, 16'd0, 16'd0, 0);
    frame(8'h2D, 0, -1, 1'b0, 16'd0, 16'd0, 16'd0, 5);
    spot(3);
    frame(8'hAD, 1, -1, 1'b0, 16'd0, 16'd0, 16'd0, 0);
    send_sample(16'h1234, 16'hABCD, 16'h00FF);
    frame(8'hF2, 6, -1, 1'b0, 16'd0, 16'd0, 16'd0, 0);
    frame(8'h2D, 1, 8'h08, 1'b0, 16'd0, 16'd0, 16'd0, 0);
    frame(8'hAD, 1, -1, 1'b0, 16'd0, 16'd0, 16'd0, 0);
    frame(8'h00, 1, 8'h55, 1'b0, 16'd0, 16'd0, 16'd0, 0);
    spot(3);
    frame(8'h80, 1, -1, 1'b0, 16'd0, 16'd0, 16'd0, 0);
    frame(8'hF2, 6, -1, 1'b1, 16'h7777, 16'hABCD, 16'h00FF, 0);
    frame(8'hF2, 2, -1, 1'b0, 16'd0, 16'd0, 16'd0, 0);
    frame(8'hFF, 2, -1, 1'b0, 16'd0, 16'd0, 16'd0, 0);
    frame(8'h6C, 3, -1, 1'b0, 16'd0, 16'd0, 16'd0, 0);
    frame(8'hEC, 3, -1, 1'b0, 16'd0, 16'd0, 16'd0, 0);

    for (int n = 0; n < 24; n++) begin
      rcmd = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0)
        send_sample(16'($urandom), 16'($urandom), 16'($urandom));
      frame(rcmd, $urandom_range(1, 4), -1, ($urandom_range(0, 3) == 0),
            16'($urandom), 16'($urandom), 16'($urandom), 0);
      if ($urandom_range(0, 3) == 0) frame({2'b11, rcmd[5:0]}, 2, -1, 1'b0, 16'd0, 16'd0, 16'd0, 0);
    end

    @(negedge clk);
    spi_cs = 1'b0;
    clk_wait(6);
    spi_bits(8'h80, 8);
    rst = 1'b1;
    clk_wait(2);
    rst = 1'b0;
    model_reset();
    spi_bits(8'($urandom_range(0, 255)), 8);
    spi_bits(8'($urandom_range(0, 255)), 8);
    clk_wait(HALF);
    spi_cs = 1'b1;
    clk_wait(10);
    spot_busy = 1'b0;
    spot_oe = 1'b0;
    spot(2);
    spot(3);
    frame(8'h80, 1, -1, 1'b0, 16'd0, 16'd0, 16'd0, 0);
    frame(8'hED, 1, -1, 1'b0, 16'd0, 16'd0, 16'd0, 0);

    clk_wait(5);
    @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
